boot_frame_loader: RTL and testbench
====================================

# boot_frame_loader

Synthesizable UART boot-image loader: consumes the byte stream from the UART RX FIFO and detects a halt sync sequence. It then parses a little-endian start address and byte count, writes the payload to memory over the req/gnt data bus, and releases the CPU on a run sync sequence. It generalises the host boot protocol in three ways: configurable data width, configurable sync length, and an optional checksum. It also adds inter-byte timeout and error recovery. It sits between `UART_wb` RX and the instruction/data memory write port, and drives the CPU halt line.

## Interface
- `STP_BYTE`, 8'hA5, halt sync byte
- `ON_BYTE`, 8'h5A, run sync byte
- `SYNC_CNT`, 33, consecutive sync bytes required (2..255)
- `ADDR_W`, 32, bus address width
- `DATA_W`, 32, bus data width; multiple of 8, 8..64
- `CSUM_EN`, 0, 1 = one checksum byte follows payload
- `TIMEOUT_CYC`, 1_000_000, max Clk cycles between bytes once halted; 0 = disabled
- `Clk` in 1 system clock
- `Rst` in 1 reset; synchronous, active-high
- `rx_data` in 8 byte from RX FIFO
- `rx_valid` in 1 byte available
- `rx_ready` out 1 byte accepted when `rx_valid && rx_ready`
- `req` out 1 bus write request
- `gnt` in 1 bus grant
- `we` out 1 write enable; equals `req`
- `addr` out ADDR_W word-aligned write address
- `wdata` out DATA_W write data
- `be` out DATA_W/8 byte enables
- `cpu_halt` out 1 holds CPU in reset/stall
- `done` out 1 one-cycle pulse on successful release
- `err` out 1 error level; cleared by next halt sync
- `err_code` out 2 0 none, 1 misaligned base, 2 timeout, 3 checksum

## Operation
- Frame structure, in order:
  - SYNC_CNT × STP_BYTE
  - 4 address bytes, LSB first; upper bytes beyond ADDR_W ignored
  - 4 length bytes, LSB first
  - `len` payload bytes, LSB of each word first
  - [checksum byte]
  - SYNC_CNT × ON_BYTE
- States: IDLE, ADDR, LEN, DATA, WR, CSUM, WAIT_ON, ERR.
- IDLE: `cpu_halt`=0. The sync detector counts consecutive STP_BYTE; any other byte clears the count. When the count reaches SYNC_CNT → ADDR, set `cpu_halt`, clear `err`.
- ADDR: the next 4 bytes are taken as address regardless of value. If the base address is not DATA_W/8-aligned → ERR, code 1.
- LEN: 4 bytes. If len==0 → CSUM (CSUM_EN=1) or WAIT_ON.
- DATA: shift bytes into the word at lane `k`; `be[k]` is set.
  - On a full word, or on the final payload byte → WR.
  - A partial last word carries only the received lanes in `be`.
- WR: `req`=`we`=1 and `rx_ready`=0 until `gnt` is sampled high. Then `addr += DATA_W/8` and the state returns to DATA, or to CSUM/WAIT_ON after the last word.
- CSUM: the checksum is the 8-bit sum mod 256 of all address, length and payload bytes. On mismatch → ERR, code 3.
- WAIT_ON: count consecutive ON_BYTE; other bytes clear the count. At SYNC_CNT → IDLE, `cpu_halt`=0, `done` pulse.
- ERR: `cpu_halt` stays 1 and `err`=1. The STP sync detector is active; a full STP sync → ADDR.
- Timeout: in ADDR, LEN, DATA, CSUM and WAIT_ON, a gap counter increments each cycle with no accepted byte. When it reaches TIMEOUT_CYC → ERR, code 2. The counter does not run in WR.
- A STP sync seen in ADDR..WAIT_ON is payload, not a restart. The only restart paths are ERR or reset.

## Timing
- Reset values:
  - `cpu_halt` 0, `req`/`we` 0, `addr`/`wdata`/`be` 0
  - `done` 0, `err` 0, `err_code` 0, `rx_ready` 1
  - state IDLE, all counters 0
- `cpu_halt` rises the cycle after the SYNC_CNT-th STP byte is accepted.
- `req` rises the cycle after the byte completing a word is accepted. `addr`, `wdata` and `be` are stable while `req`=1. `req` drops the cycle after `gnt` is sampled high; `gnt` in the same cycle as `req` rises → 1-cycle transaction.
- `rx_ready` = 0 throughout WR, 1 otherwise.
- `done` and `cpu_halt` falling both occur the cycle after the last ON byte is accepted.
- A reset mid-frame aborts immediately: no partial word is written and `cpu_halt` drops.

## Structure
- Shared package `boot_pkg`:
  - state enum `boot_state_t`
  - error code constants `BOOT_ERR_*`
  - default STP/ON byte constants
- Sub-module `boot_seq_det`: consecutive-match byte counter with `match_byte`, `cnt_max`, `clr` and a `hit` pulse. It is instantiated once; its compare byte is muxed between STP and ON by state.

## Test plan
- DATA_W=32, SYNC_CNT=33. Send 33×A5, addr 0x0000_1000, len 8, payload 0x11..0x88, 33×5A → two writes: 0x1000 = 0x44332211, 0x1004 = 0x88776655, `be`=4'hF. `cpu_halt` spans the frame and there is one `done`.
- len 6 → second write at 0x1004 with `be`=4'b0011 and data 0x00006655 in the low lanes.
- `gnt` held low 20 cycles on the first word → `req` held, `rx_ready`=0 and no bytes dropped. Writes are identical to the first scenario.
- 32×A5, one 0x00, then 33×A5 → halt only after the second run. The byte after that run is taken as address byte 0.
- CSUM_EN=1 with a wrong checksum → `err`=1, code 3, `cpu_halt`=1. A new valid frame clears `err` and ends with `done`.
- TIMEOUT_CYC=100: stall after 2 address bytes → ERR, code 2 exactly 100 cycles after the last accepted byte. Base address 0x1002 → ERR, code 1, with no bus writes.

Source files
------------

// File: rtl/boot_frame_loader_pkg.sv
// rtl/boot_frame_loader_pkg.sv - shared types and constants for the UART boot-image loader
// Contents: boot_state_t (loader FSM states), BOOT_ERR_* (err_code values),
//           BOOT_STP_BYTE / BOOT_ON_BYTE (default halt/run sync bytes).
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_WR,
    ST_CSUM,
    ST_WAIT_ON,
    ST_ERR
  } boot_state_t;

  localparam logic [1:0] BOOT_ERR_NONE     = 2'd0;
  localparam logic [1:0] BOOT_ERR_MISALIGN = 2'd1;
  localparam logic [1:0] BOOT_ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] BOOT_ERR_CSUM     = 2'd3;

  localparam logic [7:0] BOOT_STP_BYTE = 8'hA5;
  localparam logic [7:0] BOOT_ON_BYTE  = 8'h5A;

endpackage

// File: rtl/boot_frame_loader_if.sv
// rtl/boot_frame_loader_if.sv - byte-stream and memory-write bus interfaces of the boot loader
// boot_rx_if : rx_data[7:0], rx_valid (master -> slave), rx_ready (slave -> master).
// boot_bus_if: req, we, addr, wdata, be (master -> slave), gnt (slave -> master).
interface boot_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, rx_valid, input rx_ready);
  modport slave  (input rx_data, rx_valid, output rx_ready);
endinterface

interface boot_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                req;
  logic                gnt;
  logic                we;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] be;

  modport master (output req, we, addr, wdata, be, input gnt);
  modport slave  (input req, we, addr, wdata, be, output gnt);
endinterface

// File: rtl/boot_seq_det.sv
// rtl/boot_seq_det.sv - counts consecutive accepted bytes equal to match_byte
// Ports: Clk, Rst (sync, active-high); data/vld = accepted byte; match_byte = byte to count;
//        cnt_max = run length; clr = drop the count; hit = combinational pulse on the
//        accepted byte that completes the run.
module boot_seq_det (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] data,
  input  logic       vld,
  input  logic [7:0] match_byte,
  input  logic [7:0] cnt_max,
  input  logic       clr,
  output logic       hit
);
  logic [7:0] cnt;
  logic       is_match;

  assign is_match = vld && (data == match_byte);
  assign hit      = is_match && (cnt == cnt_max - 8'd1);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (vld) begin
      // a completed run restarts counting so the next run needs a full count again
      cnt <= (is_match && !hit) ? cnt + 8'd1 : 8'd0;
    end
  end
endmodule

// File: rtl/boot_frame_loader.sv
// rtl/boot_frame_loader.sv - UART boot-image loader: sync, header parse, payload write, CPU release
// Ports: Clk, Rst (sync, active-high); rx (boot_rx_if.slave) byte stream from RX FIFO;
//        bus (boot_bus_if.master) memory write port; cpu_halt holds the CPU;
//        done one-cycle release pulse; err / err_code error level and cause.
module boot_frame_loader
  import boot_pkg::*;
#(
  parameter logic [7:0]  STP_BYTE    = BOOT_STP_BYTE,
  parameter logic [7:0]  ON_BYTE     = BOOT_ON_BYTE,
  parameter int          SYNC_CNT    = 33,
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 32,
  parameter bit          CSUM_EN     = 1'b0,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic       Clk,
  input  logic       Rst,
  boot_rx_if.slave   rx,
  boot_bus_if.master bus,
  output logic       cpu_halt,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);
  localparam int          BYTES      = DATA_W / 8;
  localparam int          LANE_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES - 1);
  localparam logic [31:0] ALIGN_MASK = 32'(BYTES - 1);
  localparam logic [31:0] TMO        = 32'(TIMEOUT_CYC);
  localparam boot_state_t AFTER_DATA = CSUM_EN ? ST_CSUM : ST_WAIT_ON;

  boot_state_t       state, state_n;
  logic              acc, hit, det_clr, timeout, gap_run;
  logic [7:0]        match_byte;
  logic [1:0]        code_n;
  logic [31:0]       field, field_n, remaining, gap;
  logic [1:0]        fcnt;
  logic [LANE_W-1:0] lane;
  logic [7:0]        csum;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BYTES-1:0]  be_q;

  assign acc         = rx.rx_valid && rx.rx_ready;
  assign rx.rx_ready = (state != ST_WR);
  assign bus.req     = (state == ST_WR);
  assign bus.we      = (state == ST_WR);
  assign bus.addr    = addr_q;
  assign bus.wdata   = wdata_q;
  assign bus.be      = be_q;
  assign cpu_halt    = (state != ST_IDLE);

  // Address and length arrive LSB first: shifting in from the top leaves the
  // little-endian value in place after the fourth byte.
  assign field_n = {rx.rx_data, field[31:8]};

  assign gap_run = state inside {ST_ADDR, ST_LEN, ST_DATA, ST_CSUM, ST_WAIT_ON};
  assign timeout = (TMO != 32'd0) && gap_run && !acc && (gap == TMO - 32'd1);

  // One detector serves both syncs; it is cleared on every state change so a
  // partial run never carries over between the STP and ON byte comparisons.
  assign match_byte = (state == ST_WAIT_ON) ? ON_BYTE : STP_BYTE;
  assign det_clr    = !(state inside {ST_IDLE, ST_ERR, ST_WAIT_ON}) || (state_n != state);

  boot_seq_det u_seq_det (
    .Clk        (Clk),
    .Rst        (Rst),
    .data       (rx.rx_data),
    .vld        (acc),
    .match_byte (match_byte),
    .cnt_max    (8'(SYNC_CNT)),
    .clr        (det_clr),
    .hit        (hit)
  );

  always_ff @(posedge Clk) begin
    if (Rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    code_n  = BOOT_ERR_NONE;
    case (state)
      ST_IDLE, ST_ERR: if (hit) state_n = ST_ADDR;
      ST_ADDR: begin
        if (acc && fcnt == 2'd3) begin
          if ((field_n & ALIGN_MASK) != 32'd0) begin
            state_n = ST_ERR;
            code_n  = BOOT_ERR_MISALIGN;
          end else begin
            state_n = ST_LEN;
          end
        end
      end
      ST_LEN:  if (acc && fcnt == 2'd3) state_n = (field_n == 32'd0) ? AFTER_DATA : ST_DATA;
      ST_DATA: if (acc && (lane == LAST_LANE || remaining == 32'd1)) state_n = ST_WR;
      ST_WR:   if (bus.gnt) state_n = (remaining == 32'd0) ? AFTER_DATA : ST_DATA;
      ST_CSUM: begin
        if (acc) begin
          if (rx.rx_data != csum) begin
            state_n = ST_ERR;
            code_n  = BOOT_ERR_CSUM;
          end else begin
            state_n = ST_WAIT_ON;
          end
        end
      end
      ST_WAIT_ON: if (hit) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
    if (timeout) begin
      state_n = ST_ERR;
      code_n  = BOOT_ERR_TIMEOUT;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= BOOT_ERR_NONE;
      gap       <= 32'd0;
      field     <= 32'd0;
      remaining <= 32'd0;
      fcnt      <= 2'd0;
      lane      <= '0;
      csum      <= 8'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
    end else begin
      done <= 1'b0;
      gap  <= (gap_run && !acc) ? gap + 32'd1 : 32'd0;
      if (state_n == ST_ERR && state != ST_ERR) begin
        err      <= 1'b1;
        err_code <= code_n;
      end
      case (state)
        ST_IDLE, ST_ERR: begin
          if (hit) begin
            err      <= 1'b0;
            err_code <= BOOT_ERR_NONE;
            fcnt     <= 2'd0;
            csum     <= 8'd0;
            lane     <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
          end
        end
        ST_ADDR, ST_LEN: begin
          if (acc) begin
            field <= field_n;
            fcnt  <= fcnt + 2'd1;
            csum  <= csum + rx.rx_data;
            if (fcnt == 2'd3) begin
              if (state == ST_ADDR) addr_q    <= field_n[ADDR_W-1:0];
              else                  remaining <= field_n;
            end
          end
        end
        ST_DATA: begin
          if (acc) begin
            for (int i = 0; i < BYTES; i++) begin
              if (lane == LANE_W'(i)) begin
                wdata_q[8*i +: 8] <= rx.rx_data;
                be_q[i]           <= 1'b1;
              end
            end
            lane      <= lane + LANE_W'(1);
            remaining <= remaining - 32'd1;
            csum      <= csum + rx.rx_data;
          end
        end
        ST_WR: begin
          // unused lanes of the next (possibly partial) word must read as zero
          if (bus.gnt) begin
            addr_q  <= addr_q + ADDR_W'(BYTES);
            wdata_q <= '0;
            be_q    <= '0;
            lane    <= '0;
          end
        end
        ST_WAIT_ON: if (hit) done <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_boot_frame_loader.sv
// tb/tb_boot_frame_loader.sv - randomized self-checking bench for boot_frame_loader
module tb_boot_frame_loader;
  localparam logic [7:0] STP = 8'hA5;
  localparam logic [7:0] ON  = 8'h5A;
  localparam int         NSYNC = 33;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_halt, done, err;
  logic [1:0] err_code;

  boot_rx_if rx_if ();
  boot_bus_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  boot_frame_loader #(
    .SYNC_CNT    (NSYNC),
    .ADDR_W      (32),
    .DATA_W      (32),
    .CSUM_EN     (1'b1),
    .TIMEOUT_CYC (100)
  ) dut (
    .Clk      (clk),
    .Rst      (rst),
    .rx       (rx_if),
    .bus      (bus_if),
    .cpu_halt (cpu_halt),
    .done     (done),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  wr_t exp_q[$];
  wr_t act_q[$];
  int  req_lens[$];
  logic [7:0] pl[$];
  bit  mon_en = 1'b0;
  bit  exp_halt = 1'b0, exp_err = 1'b0, exp_done = 1'b0;
  logic [1:0] exp_code = 2'd0;
  int  done_cnt = 0;
  int  stall_left = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // bus slave: random grant, or grant withheld for the first stall_left request cycles
  initial begin
    bus_if.gnt = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
        bus_if.gnt = 1'b0;
        if (bus_if.req) stall_left--;
      end else begin
        bus_if.gnt = ($urandom_range(0, 1) == 1);
      end
    end
  end

  // compare process: every output checked against the model's expectations each cycle
  initial begin
    logic        p_req = 1'b0, p_gnt = 1'b0;
    logic [31:0] p_addr = '0, p_data = '0;
    logic [3:0]  p_be = '0;
    int          rlen = 0;
    wr_t         w;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("cpu_halt", 64'(cpu_halt), 64'(exp_halt));
        chk("err", 64'(err), 64'(exp_err));
        chk("err_code", 64'(err_code), 64'(exp_code));
        chk("done", 64'(done), 64'(exp_done));
        chk("we_eq_req", 64'(bus_if.we), 64'(bus_if.req));
        chk("rx_ready", 64'(rx_if.rx_ready), 64'(!bus_if.req));
        if (done) done_cnt++;
        if (p_req && p_gnt) chk("req_drop", 64'(bus_if.req), 64'd0);
        if (bus_if.req && p_req && !p_gnt) begin
          chk("addr_stable", 64'(bus_if.addr), 64'(p_addr));
          chk("wdata_stable", 64'(bus_if.wdata), 64'(p_data));
          chk("be_stable", 64'(bus_if.be), 64'(p_be));
        end
        if (bus_if.req) rlen++;
        else if (p_req) begin
          req_lens.push_back(rlen);
          rlen = 0;
        end
        if (bus_if.req && bus_if.gnt) begin
          act_q.push_back('{bus_if.addr, bus_if.wdata, bus_if.be});
          chk("write_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk("wr_addr", 64'(bus_if.addr), 64'(w.addr));
            chk("wr_data", 64'(bus_if.wdata), 64'(w.data));
            chk("wr_be", 64'(bus_if.be), 64'(w.be));
          end
        end
        p_req  = bus_if.req;
        p_gnt  = bus_if.gnt;
        p_addr = bus_if.addr;
        p_data = bus_if.wdata;
        p_be   = bus_if.be;
      end
    end
  end

  // byte driver: returns 1 time unit after the clock edge that accepted the byte
  task automatic send_byte(input logic [7:0] b);
    int   n;
    logic rdy;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    rx_if.rx_data  = b;
    rx_if.rx_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = rx_if.rx_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 400);
    if (!rdy) chk("rx_accept", 64'(rdy), 64'd1);
    rx_if.rx_valid = 1'b0;
  endtask

  task automatic send_run(input logic [7:0] b, input int n);
    repeat (n) send_byte(b);
  endtask

  task automatic send_le32(input logic [31:0] v, input int nb);
    for (int i = 0; i < nb; i++) send_byte(v[8*i +: 8]);
  endtask

  task automatic halt_sync();
    send_run(STP, NSYNC);
    exp_halt = 1'b1;
    exp_err  = 1'b0;
    exp_code = 2'd0;
  endtask

  // full frame; the model derives expected writes and checksum from the frame contents
  task automatic run_frame(input logic [31:0] a, input logic [31:0] n, input bit bad_csum);
    logic [7:0]  cs;
    logic [31:0] nl;
    wr_t         w;
    cs = 8'd0;
    nl = n;
    for (int i = 0; i < 4; i++) cs = cs + a[8*i +: 8] + nl[8*i +: 8];
    halt_sync();
    send_le32(a, 4);
    if (a[1:0] != 2'd0) begin
      exp_err  = 1'b1;
      exp_code = 2'd1;
      return;
    end
    for (int k = 0; k < int'(n); k += 4) begin
      w = '{a + 32'(k), 32'd0, 4'd0};
      for (int j = 0; j < 4 && k + j < int'(n); j++) begin
        w.data[8*j +: 8] = pl[k+j];
        w.be[j] = 1'b1;
      end
      exp_q.push_back(w);
    end
    send_le32(n, 4);
    for (int i = 0; i < int'(n); i++) begin
      send_byte(pl[i]);
      cs = cs + pl[i];
    end
    send_byte(bad_csum ? ~cs : cs);
    if (bad_csum) begin
      exp_err  = 1'b1;
      exp_code = 2'd3;
      return;
    end
    send_run(ON, NSYNC);
    exp_halt = 1'b0;
    exp_done = 1'b1;
    @(posedge clk);
    #1;
    exp_done = 1'b0;
    chk("writes_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic fill_seq(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'(8'h11 * (i + 1)));
  endtask

  task automatic fill_rand(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
  endtask

  task automatic check_two_writes(input string tag, input logic [31:0] d1, input logic [3:0] be1);
    chk({tag, "_nwr"}, 64'(act_q.size()), 64'd2);
    if (act_q.size() >= 2) begin
      chk({tag, "_a0"}, 64'(act_q[0].addr), 64'h1000);
      chk({tag, "_d0"}, 64'(act_q[0].data), 64'h44332211);
      chk({tag, "_be0"}, 64'(act_q[0].be), 64'hF);
      chk({tag, "_a1"}, 64'(act_q[1].addr), 64'h1004);
      chk({tag, "_d1"}, 64'(act_q[1].data), 64'(d1));
      chk({tag, "_be1"}, 64'(act_q[1].be), 64'(be1));
    end
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int         d0;
    logic [7:0] b;
    rst = 1'b1;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_halt", 64'(cpu_halt), 64'd0);
    chk("rst_req", 64'(bus_if.req), 64'd0);
    chk("rst_we", 64'(bus_if.we), 64'd0);
    chk("rst_addr", 64'(bus_if.addr), 64'd0);
    chk("rst_wdata", 64'(bus_if.wdata), 64'd0);
    chk("rst_be", 64'(bus_if.be), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_code", 64'(err_code), 64'd0);
    chk("rst_rx_ready", 64'(rx_if.rx_ready), 64'd1);
    rst = 1'b0;
    mon_en = 1'b1;

    // basic frame, 8 bytes
    act_q.delete();
    d0 = done_cnt;
    fill_seq(8);
    run_frame(32'h1000, 32'd8, 1'b0);
    check_two_writes("s1", 32'h88776655, 4'hF);
    chk("s1_done", 64'(done_cnt - d0), 64'd1);

    // partial last word
    act_q.delete();
    fill_seq(6);
    run_frame(32'h1000, 32'd6, 1'b0);
    check_two_writes("s2", 32'h00006655, 4'b0011);

    // grant withheld for 20 request cycles on the first word
    act_q.delete();
    req_lens.delete();
    stall_left = 20;
    fill_seq(8);
    run_frame(32'h1000, 32'd8, 1'b0);
    check_two_writes("s3", 32'h88776655, 4'hF);
    chk("s3_req_held", 64'(req_lens.size() > 0 && req_lens[0] >= 21), 64'd1);

    // broken sync run must not halt; the byte after the full run is address byte 0
    send_run(STP, NSYNC - 1);
    send_byte(8'h00);
    chk("s4_no_halt", 64'(cpu_halt), 64'd0);
    fill_rand(4);
    run_frame(32'h2000, 32'd4, 1'b0);

    // wrong checksum, then recovery with a valid frame
    fill_rand(5);
    run_frame(32'h3000, 32'd5, 1'b1);
    chk("s5_err", 64'(err), 64'd1);
    chk("s5_code", 64'(err_code), 64'd3);
    chk("s5_halt", 64'(cpu_halt), 64'd1);
    d0 = done_cnt;
    fill_rand(7);
    run_frame(32'h3100, 32'd7, 1'b0);
    chk("s5_recover_done", 64'(done_cnt - d0), 64'd1);

    // inter-byte timeout after two address bytes
    halt_sync();
    send_byte(8'h00);
    send_byte(8'h10);
    repeat (99) begin
      @(posedge clk);
      #1;
    end
    chk("tmo_not_early", 64'(err), 64'd0);
    @(posedge clk);
    #1;
    exp_err  = 1'b1;
    exp_code = 2'd2;
    chk("tmo_err", 64'(err), 64'd1);
    chk("tmo_code", 64'(err_code), 64'd2);
    fill_rand(3);
    run_frame(32'h5000, 32'd3, 1'b0);

    // misaligned base: error, no bus writes
    act_q.delete();
    fill_rand(4);
    run_frame(32'h1002, 32'd4, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("mis_code", 64'(err_code), 64'd1);
    chk("mis_no_writes", 64'(act_q.size()), 64'd0);
    fill_rand(2);
    run_frame(32'h6000, 32'd2, 1'b0);

    // reset mid-word aborts without a partial write
    act_q.delete();
    halt_sync();
    send_le32(32'h4000, 4);
    send_le32(32'd8, 4);
    send_byte(8'h01);
    send_byte(8'h02);
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_halt = 1'b0;
    exp_err  = 1'b0;
    exp_code = 2'd0;
    mon_en = 1'b1;
    chk("mid_rst_halt", 64'(cpu_halt), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_rst_no_write", 64'(act_q.size()), 64'd0);

    // zero-length payload
    act_q.delete();
    pl.delete();
    run_frame(32'h7000, 32'd0, 1'b0);
    chk("len0_no_write", 64'(act_q.size()), 64'd0);

    // randomized frames with leading junk
    for (int f = 0; f < 8; f++) begin
      repeat ($urandom_range(0, 4)) begin
        b = 8'($urandom);
        if (b == STP) b = 8'h00;
        send_byte(b);
      end
      d0 = $urandom_range(1, 13);
      fill_rand(d0);
      run_frame($urandom & 32'hFFFF_FFFC, 32'(d0), 1'b0);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("final_exp_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
